serialize_lanes: RTL and testbench
==================================

// Module: serialize_lanes
// PURPOSE
//  Downstream neighbour of the DTI decoupling FIFO. Takes one wide word of up
//  to LANES packed elements, plus a valid-lane count and an end-of-transaction
//  (eot) flag, and emits the elements one per cycle on a narrow DTI stream.
//  Marks the last element of each transaction with eot.
//  Word buffered internally; next word accepted on cycle of last-lane handshake.
// PARAMETERS
//  LANES  4                  number of element lanes in one din word (>=2)
//  W      16                 element width in bits
//  LEN_W  $clog2(LANES+1)    width of lane-count field (derived, do not override)
// PORTS
//  clk    in   1                   single clock, all logic on posedge
//  rst    in   1                   reset, synchronous, active-low (0 = reset)
//  din    dti.consumer  1+LEN_W+LANES*W  {eot, len, lanes}; lane0 = bits [W-1:0]
//  dout   dti.producer  1+W              {eot, element}
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state IDLE, idx 0, buffer invalid.
//    Outputs during/after reset: dout.valid 0, din.ready 1.
//  - States: IDLE (buffer empty), BUSY (buffer holds word, idx = next lane).
//  - IDLE: din.ready=1; on din.valid & len!=0 -> latch word, idx<=0, BUSY.
//  - din handshake with len==0: word consumed, nothing emitted, stay IDLE.
//  - len>LANES: clamped to LANES.
//  - BUSY: dout.valid=1; dout.data = {buf_eot & last, buf_lane[idx]}.
//    last = (idx == len_buf-1).
//  - BUSY, dout.ready & !last: idx<=idx+1.
//  - BUSY, dout.ready & last: din.ready=1 combinationally this cycle.
//    If din.valid & len!=0: reload buffer, idx<=0, stay BUSY (no bubble).
//    Otherwise go IDLE. A len==0 word here is consumed, then IDLE.
//  - BUSY & !(dout.ready & last): din.ready=0.
//  - dout.data/valid held stable while dout.valid & !dout.ready (DTI rule).
//    din.data is not required to stay stable after handshake.
//  - Latency: din handshake -> first dout.valid = 1 cycle.
//    Throughput: 1 element/cycle, len cycles per word when dout.ready is held.
//  - eot only on the final element of a word whose eot bit was set.
//    A word with eot=0 produces no eot output.
//  - dout.ready=0 for many cycles: idx and buffer frozen, no element lost or
//    duplicated.
//  - Reset mid-word: buffered word discarded, no further output; IDLE next cycle.
//  - idx width LEN_W; never wraps past len_buf-1.
//  - No combinational path din.valid -> dout.valid.
//    din.ready depends combinationally on dout.ready (intentional).
//    Place a decouple stage upstream to break the chain where needed.
// STRUCTURE
//  - Package serialize_pkg: function len_w(lanes) = $clog2(lanes+1);
//    typedef enum logic {IDLE, BUSY} ser_state_t;
//    parameterised field offsets for the {eot,len,lanes} din layout.
//  - No sub-module: lane select is an indexed part-select buf[idx*W +: W].
//    One always_ff for state/idx/buffer; one always_comb for outputs.
// TESTING  (LANES=4, W=16)
//  - Basic: word {eot=1,len=3,lanes=0x0004_0003_0002_0001}, dout.ready=1 ->
//    dout 0x0001,0x0002,0x0003 on 3 consecutive cycles, eot only with 0x0003.
//  - Back-to-back: two len=4 words, din.valid and dout.ready held ->
//    8 elements in 8 consecutive cycles, din.ready high only on cycles 4 and 8.
//  - Backpressure: dout.ready random 30% -> order and eot match a scoreboard.
//    dout.data stable every stalled cycle.
//  - Edge lengths: len=0 -> accepted, no output.
//    len=7 -> treated as 4.
//    len=1,eot=1 -> single element with eot.
//  - Reset mid-word: rst=0 after 2nd of 4 elements -> dout.valid=0 next cycle,
//    din.ready=1, and a new word afterwards is emitted from lane0.
//  - eot=0 word followed by eot=1 word (len 2 each) ->
//    eot asserted only on the 4th output.

Source files
------------

// File: rtl/serialize_lanes_pkg.sv
// Shared types and din field layout helpers for the lane serializer.
// Layout of one din word, MSB first: {eot, len[LEN_W-1:0], lanes[LANES*W-1:0]}.
package serialize_pkg;

    typedef enum logic {IDLE, BUSY} ser_state_t;

    function automatic int len_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic int len_lsb(input int lanes, input int w);
        return lanes * w;
    endfunction

    function automatic int eot_bit(input int lanes, input int w);
        return lanes * w + len_w(lanes);
    endfunction

    function automatic int din_w(input int lanes, input int w);
        return 1 + len_w(lanes) + lanes * w;
    endfunction

endpackage

// File: rtl/serialize_lanes.sv
// Buffers one wide multi-lane word and emits its valid lanes one per cycle,
// flagging the final element of an eot word.
module serialize_lanes
    import serialize_pkg::*;
#(
    parameter int LANES = 4,
    parameter int W     = 16,
    localparam int LEN_W = len_w(LANES),
    localparam int DIN_W = din_w(LANES, W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_din_valid,
    output logic             o_din_ready,
    input  logic [DIN_W-1:0] i_din_data,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic [W:0]       o_dout_data
);

    localparam int LEN_LSB = len_lsb(LANES, W);
    localparam int EOT_BIT = eot_bit(LANES, W);

    ser_state_t         r_state;
    logic [LEN_W-1:0]   r_idx;
    logic [LEN_W-1:0]   r_len;
    logic               r_eot;
    logic [LANES*W-1:0] r_lanes;

    logic [LEN_W-1:0]   w_len_in;
    logic [LEN_W-1:0]   w_len_clamp;
    logic               w_last;
    logic               w_load;

    always_comb begin
        w_len_in    = i_din_data[LEN_LSB +: LEN_W];
        w_len_clamp = (w_len_in > LEN_W'(LANES)) ? LEN_W'(LANES) : w_len_in;
        w_last      = (r_idx == r_len - 1'b1);

        // Outputs are forced idle while reset is held so nothing leaks out
        // of a discarded word; din.ready opens on the last-lane handshake.
        o_dout_valid = rst && (r_state == BUSY);
        o_dout_data  = {r_eot & w_last, r_lanes[r_idx*W +: W]};
        o_din_ready  = !rst || (r_state == IDLE) || (i_dout_ready && w_last);

        w_load = i_din_valid && o_din_ready && (w_len_clamp != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_eot   <= 1'b0;
            r_lanes <= '0;
        end else if (w_load) begin
            r_state <= BUSY;
            r_idx   <= '0;
            r_len   <= w_len_clamp;
            r_eot   <= i_din_data[EOT_BIT];
            r_lanes <= i_din_data[LANES*W-1:0];
        end else if (r_state == BUSY && i_dout_ready) begin
            // A zero-length word taken on the last handshake also lands here.
            if (w_last) r_state <= IDLE;
            else        r_idx   <= r_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_serialize_lanes.sv
// Directed checks for serialize_lanes with LANES=4, W=16.
module tb_serialize_lanes;

    localparam int LANES = 4;
    localparam int W     = 16;
    localparam int DIN_W = 1 + 3 + LANES * W;

    logic             clk = 1'b0;
    logic             rst;
    logic             din_valid;
    logic             din_ready;
    logic [DIN_W-1:0] din_data;
    logic             dout_valid;
    logic             dout_ready;
    logic [W:0]       dout_data;

    int errors = 0;
    int checks = 0;

    serialize_lanes #(.LANES(LANES), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_din_valid  (din_valid),
        .o_din_ready  (din_ready),
        .i_din_data   (din_data),
        .o_dout_valid (dout_valid),
        .i_dout_ready (dout_ready),
        .o_dout_data  (dout_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DIN_W-1:0] mk(input logic e, input logic [2:0] l,
                                            input logic [63:0] ln);
        return {e, l, ln};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then let comb outputs settle.
    task automatic cyc(input logic dv, input logic [DIN_W-1:0] dd, input logic dr);
        @(negedge clk);
        din_valid  = dv;
        din_data   = dd;
        dout_ready = dr;
        #1;
    endtask

    logic [16:0] bp_exp [10];
    logic [DIN_W-1:0] bp_words [3];

    initial begin
        int pos, wi, cnt;
        logic stalled;
        logic [16:0] held;

        rst = 1'b0; din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        chk("rst_valid", {31'b0, dout_valid}, 0);
        chk("rst_ready", {31'b0, din_ready}, 1);
        rst = 1'b1;

        // Basic len=3 eot word
        cyc(1, mk(1, 3, 64'h0004_0003_0002_0001), 1);
        chk("basic_accept", {31'b0, din_ready}, 1);
        chk("basic_lat0", {31'b0, dout_valid}, 0);
        cyc(0, '0, 1);
        chk("basic_v0", {31'b0, dout_valid}, 1);
        chk("basic_d0", {15'b0, dout_data}, 32'h0_0001);
        chk("basic_rdy0", {31'b0, din_ready}, 0);
        cyc(0, '0, 1);
        chk("basic_d1", {15'b0, dout_data}, 32'h0_0002);
        cyc(0, '0, 1);
        chk("basic_d2", {15'b0, dout_data}, 32'h1_0003);
        chk("basic_rdy2", {31'b0, din_ready}, 1);
        cyc(0, '0, 1);
        chk("basic_done", {31'b0, dout_valid}, 0);

        // Back-to-back: A (eot0) then B (eot1), then a len=0 word on cycle 8
        cyc(1, mk(0, 4, 64'hA004_A003_A002_A001), 1);
        chk("b2b_accA", {31'b0, din_ready}, 1);
        for (int k = 1; k <= 8; k++) begin
            if (k <= 4) cyc(1, mk(1, 4, 64'hB004_B003_B002_B001), 1);
            else        cyc(1, mk(0, 0, 64'hDEAD_DEAD_DEAD_DEAD), 1);
            chk("b2b_valid", {31'b0, dout_valid}, 1);
            chk("b2b_data", {15'b0, dout_data},
                (k <= 4) ? 32'h0A000 + k : ((k == 8) ? 32'h1B004 : 32'h0B000 + k - 4));
            chk("b2b_ready", {31'b0, din_ready}, (k == 4 || k == 8) ? 1 : 0);
        end
        cyc(0, '0, 1);
        chk("b2b_idle", {31'b0, dout_valid}, 0);

        // Edge lengths: len=0 in IDLE, then len=1 eot
        cyc(1, mk(1, 0, 64'h1234_1234_1234_1234), 1);
        chk("len0_ready", {31'b0, din_ready}, 1);
        cyc(0, '0, 1);
        chk("len0_none", {31'b0, dout_valid}, 0);
        cyc(1, mk(1, 1, 64'h9999_9999_9999_0042), 1);
        cyc(0, '0, 1);
        chk("len1_data", {15'b0, dout_data}, 32'h1_0042);
        chk("len1_valid", {31'b0, dout_valid}, 1);
        cyc(0, '0, 1);
        chk("len1_done", {31'b0, dout_valid}, 0);

        // Backpressure against a hand-written expected stream (len=7 clamps to 4)
        bp_words[0] = mk(0, 4, 64'h00C4_00C3_00C2_00C1);
        bp_words[1] = mk(1, 2, 64'hFFFF_FFFF_00D2_00D1);
        bp_words[2] = mk(1, 7, 64'h00E4_00E3_00E2_00E1);
        bp_exp = '{17'h000C1, 17'h000C2, 17'h000C3, 17'h000C4, 17'h000D1,
                   17'h100D2, 17'h000E1, 17'h000E2, 17'h000E3, 17'h100E4};
        pos = 0; wi = 0; cnt = 0; stalled = 1'b0; held = '0;
        while (pos < 10 && cnt < 400) begin
            cyc(wi < 3, (wi < 3) ? bp_words[wi] : '0, $urandom_range(0, 9) < 3);
            if (dout_valid) begin
                if (stalled) chk("bp_stable", {15'b0, dout_data}, {15'b0, held});
                if (dout_ready) begin
                    chk("bp_data", {15'b0, dout_data}, {15'b0, bp_exp[pos]});
                    pos++;
                end
            end
            stalled = dout_valid && !dout_ready;
            held    = dout_data;
            if (din_valid && din_ready) wi++;
            cnt++;
        end
        chk("bp_all_out", pos, 10);
        cyc(0, '0, 1);
        chk("bp_idle", {31'b0, dout_valid}, 0);

        // Reset after the second of four elements
        cyc(1, mk(1, 4, 64'h5004_5003_5002_5001), 1);
        cyc(0, '0, 1);
        chk("rmw_d0", {15'b0, dout_data}, 32'h0_5001);
        cyc(0, '0, 1);
        chk("rmw_d1", {15'b0, dout_data}, 32'h0_5002);
        rst = 1'b0;
        cyc(0, '0, 1);
        rst = 1'b1;
        cyc(0, '0, 1);
        chk("rmw_valid", {31'b0, dout_valid}, 0);
        chk("rmw_ready", {31'b0, din_ready}, 1);
        cyc(1, mk(0, 2, 64'h0000_0000_6002_6001), 1);
        cyc(0, '0, 1);
        chk("rmw_new0", {15'b0, dout_data}, 32'h0_6001);
        cyc(0, '0, 1);
        chk("rmw_new1", {15'b0, dout_data}, 32'h0_6002);

        // eot=0 word then eot=1 word, len 2 each
        cyc(1, mk(0, 2, 64'h0000_0000_7002_7001), 1);
        cyc(1, mk(1, 2, 64'h0000_0000_8002_8001), 1);
        chk("eot_o1", {15'b0, dout_data}, 32'h0_7001);
        cyc(1, mk(1, 2, 64'h0000_0000_8002_8001), 1);
        chk("eot_o2", {15'b0, dout_data}, 32'h0_7002);
        chk("eot_rdy2", {31'b0, din_ready}, 1);
        cyc(0, '0, 1);
        chk("eot_o3", {15'b0, dout_data}, 32'h0_8001);
        cyc(0, '0, 1);
        chk("eot_o4", {15'b0, dout_data}, 32'h1_8002);
        cyc(0, '0, 1);
        chk("eot_idle", {31'b0, dout_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
